// File: rtl/sram_responder.sv
// sram_responder
//   Synchronous model of the external 16-bit SRAM, answering the memory
//   controller's RAM bus. After reset it zero-fills the array (INIT), then
//   serves backdoor loads, masked bus writes and pipelined bus reads (READY).
//
// Parameters
//   DEPTH_LOG2  log2 of array depth in 16-bit words; upper addr bits alias.
//   READ_LAT    clockFast edges from read-request sample to data valid (1..4).
//
// Ports
//   clockFast   system clock, all state on posedge
//   reset       asynchronous, active-low
//   addr        word address from the controller
//   data        bidirectional data bus, driven only for valid read data
//   wre         write enable, active-low
//   oute        output enable, active-low
//   hb_mask     upper byte lane [15:8] enable, active-low
//   lb_mask     lower byte lane [7:0] enable, active-low
//   chip_en     chip select, active-low
//   load_en     backdoor write strobe, active-high
//   load_addr   backdoor word address (aliased like addr)
//   load_data   backdoor write data, full word
//   init_done   high once the zero-fill has completed
//   rd_count    accepted bus reads, wraps
//   wr_count    accepted bus writes, wraps
module sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 1
) (
  input  logic        clockFast,
  input  logic        reset,
  input  logic [17:0] addr,
  inout  wire  [15:0] data,
  input  logic        wre,
  input  logic        oute,
  input  logic        hb_mask,
  input  logic        lb_mask,
  input  logic        chip_en,
  input  logic        load_en,
  input  logic [17:0] load_addr,
  input  logic [15:0] load_data,
  output logic        init_done,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  logic [15:0] mem [DEPTH];

  logic [0:0]  state_q, state_d;
  idx_t        fill_q, fill_d;
  logic        init_done_q, init_done_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Stage 0 holds the freshly captured request; stage READ_LAT is the
  // output register whose valid bit is drive_valid.
  logic        pipe_v_q    [READ_LAT+1];
  logic        pipe_v_d    [READ_LAT+1];
  logic [15:0] pipe_word_q [READ_LAT+1];
  logic [15:0] pipe_word_d [READ_LAT+1];

  logic        ready, bus_wr, bus_rd;
  logic        do_load, do_wr, do_rd, flush;
  logic        mem_we_hi, mem_we_lo;
  idx_t        mem_idx;
  logic [15:0] mem_wdata;
  logic [15:0] rd_word, rd_masked;
  logic        drive_valid, drive_en;

  // Only the low DEPTH_LOG2 address bits select a word; the rest alias.
  wire unused_addr_bits = ^{addr, load_addr};

  assign ready  = (state_q == ST_READY);
  assign bus_wr = !chip_en && !wre;
  assign bus_rd = !chip_en && wre && !oute;

  // Load wins over a bus write, which wins over a read.
  assign do_load = ready && load_en;
  assign do_wr   = ready && !load_en && bus_wr;
  assign do_rd   = ready && !load_en && !bus_wr && bus_rd;
  assign flush   = do_load || do_wr;

  // The word is fetched at capture time; any later write or load flushes
  // the pipeline, so a stale word can never reach the bus.
  assign rd_word   = mem[addr[DEPTH_LOG2-1:0]];
  assign rd_masked = {hb_mask ? 8'h00 : rd_word[15:8],
                      lb_mask ? 8'h00 : rd_word[7:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    fill_d      = fill_q;
    init_done_d = init_done_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    mem_we_hi   = 1'b0;
    mem_we_lo   = 1'b0;
    mem_idx     = addr[DEPTH_LOG2-1:0];
    mem_wdata   = data;

    if (state_q == ST_INIT) begin
      mem_we_hi = 1'b1;
      mem_we_lo = 1'b1;
      mem_idx   = fill_q;
      mem_wdata = 16'h0000;
      fill_d    = fill_q + idx_t'(1);
      if (&fill_q) begin
        state_d     = ST_READY;
        init_done_d = 1'b1;
      end
    end else if (do_load) begin
      mem_we_hi = 1'b1;
      mem_we_lo = 1'b1;
      mem_idx   = load_addr[DEPTH_LOG2-1:0];
      mem_wdata = load_data;
    end else if (do_wr) begin
      mem_we_hi  = !hb_mask;
      mem_we_lo  = !lb_mask;
      wr_count_d = wr_count_q + 16'd1;
    end else if (do_rd) begin
      rd_count_d = rd_count_q + 16'd1;
    end

    pipe_v_d[0]    = do_rd;
    pipe_word_d[0] = rd_masked;
    for (int i = 1; i <= READ_LAT; i++) begin
      pipe_v_d[i]    = pipe_v_q[i-1];
      pipe_word_d[i] = pipe_word_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i <= READ_LAT; i++) pipe_v_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clockFast or negedge reset) begin
    if (!reset) begin
      // NOTE: state flops use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= ST_INIT;
      fill_q      <= '0;
      init_done_q <= 1'b0;
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
      for (int i = 0; i <= READ_LAT; i++) begin
        pipe_v_q[i]    <= 1'b0;
        pipe_word_q[i] <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      init_done_q <= init_done_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      for (int i = 0; i <= READ_LAT; i++) begin
        pipe_v_q[i]    <= pipe_v_d[i];
        pipe_word_q[i] <= pipe_word_d[i];
      end
    end
  end

  // NOTE: the array has no reset branch; clearing it is the INIT fill's
  // job, which keeps it mappable onto RAM.
  always_ff @(posedge clockFast) begin
    if (mem_we_hi) mem[mem_idx][15:8] <= mem_wdata[15:8];
    if (mem_we_lo) mem[mem_idx][7:0]  <= mem_wdata[7:0];
  end

  // Drive rule is purely combinational on the live strobes so the bus is
  // released in the same cycle the controller turns it around.
  assign drive_valid = pipe_v_q[READ_LAT];
  assign drive_en    = drive_valid && !chip_en && !oute && wre;
  assign data        = drive_en ? pipe_word_q[READ_LAT] : 16'bz;

  assign init_done = init_done_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Two responders (READ_LAT=1 and READ_LAT=3) share one set of controller
//   strobes; each has its own data bus with a pull-up, so an undriven bus
//   reads 16'hFFFF. Table rows cover the READ_LAT=1 read/write/load paths;
//   hand-written sequences cover fill timing, the deep pipeline, bus
//   release and a mid-fill reset.
module tb_sram_responder;

  localparam logic [15:0] UNDRIVEN = 16'hFFFF;

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;

  typedef struct {
    op_e         op;
    logic [17:0] a;
    logic [15:0] wd;
    logic        hb;
    logic        lb;
    logic        ld;
    logic [17:0] ld_a;
    logic [15:0] ld_d;
    logic        chk_bus;
    logic [15:0] exp_bus;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
  } vec_t;

  logic        clockFast = 1'b0;
  logic        reset;
  logic [17:0] addr;
  logic        wre, oute, hb_mask, lb_mask, chip_en, load_en;
  logic [17:0] load_addr;
  logic [15:0] load_data;
  logic [15:0] tb_drv;
  logic        tb_drv_en;

  wire  [15:0] bus1, bus3;
  logic        init_done1, init_done3;
  logic [15:0] rd_count1, wr_count1, rd_count3, wr_count3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clockFast = ~clockFast;

  for (genvar b = 0; b < 16; b++) begin : g_pu
    pullup (bus1[b]);
    pullup (bus3[b]);
  end

  assign bus1 = tb_drv_en ? tb_drv : 16'bz;
  assign bus3 = tb_drv_en ? tb_drv : 16'bz;

  sram_responder #(.DEPTH_LOG2(10), .READ_LAT(1)) u_dut1 (
    .clockFast(clockFast), .reset(reset), .addr(addr), .data(bus1),
    .wre(wre), .oute(oute), .hb_mask(hb_mask), .lb_mask(lb_mask),
    .chip_en(chip_en), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .init_done(init_done1), .rd_count(rd_count1),
    .wr_count(wr_count1)
  );

  sram_responder #(.DEPTH_LOG2(10), .READ_LAT(3)) u_dut3 (
    .clockFast(clockFast), .reset(reset), .addr(addr), .data(bus3),
    .wre(wre), .oute(oute), .hb_mask(hb_mask), .lb_mask(lb_mask),
    .chip_en(chip_en), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .init_done(init_done3), .rd_count(rd_count3),
    .wr_count(wr_count3)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clockFast);
    #2;
  endtask

  task automatic drive_bus(input op_e op, input logic [17:0] a,
                           input logic [15:0] wd, input logic hb,
                           input logic lb);
    addr      = a;
    chip_en   = (op == OP_IDLE);
    wre       = (op != OP_WR);
    oute      = (op != OP_RD);
    hb_mask   = hb;
    lb_mask   = lb;
    tb_drv    = wd;
    tb_drv_en = (op == OP_WR);
  endtask

  task automatic drive_load(input logic en, input logic [17:0] a,
                            input logic [15:0] d);
    load_en   = en;
    load_addr = a;
    load_data = d;
  endtask

  // Holds a read request through the fill so any illegal drive or count
  // during INIT shows up; returns edges until init_done and drive cycles.
  task automatic run_fill(output int edges, output int driven);
    edges  = 0;
    driven = 0;
    drive_bus(OP_RD, 18'h00005, 16'h0000, 1'b0, 1'b0);
    drive_load(1'b1, 18'h00005, 16'hDEAD);
    while (edges < 2000) begin
      step();
      edges++;
      if (bus1 !== UNDRIVEN || bus3 !== UNDRIVEN) driven++;
      if (init_done1 === 1'b1) break;
    end
    drive_bus(OP_IDLE, 18'h0, 16'h0, 1'b0, 1'b0);
    drive_load(1'b0, 18'h0, 16'h0);
  endtask

  function automatic vec_t mk(op_e op, logic [17:0] a, logic [15:0] wd,
                              logic hb, logic lb, logic ld, logic [17:0] ld_a,
                              logic [15:0] ld_d, logic chk_bus,
                              logic [15:0] exp_bus, logic [15:0] exp_rd,
                              logic [15:0] exp_wr);
    vec_t v;
    v.op = op; v.a = a; v.wd = wd; v.hb = hb; v.lb = lb;
    v.ld = ld; v.ld_a = ld_a; v.ld_d = ld_d;
    v.chk_bus = chk_bus; v.exp_bus = exp_bus;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int edges, driven;

    // Each row is held for one edge; bus expectation is what the READ_LAT=1
    // part drives after that edge under the row's own strobes.
    vecs.push_back(mk(OP_RD,   18'h00005, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, UNDRIVEN, 1,  0));
    vecs.push_back(mk(OP_RD,   18'h00005, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, 16'h0000, 2,  0));
    vecs.push_back(mk(OP_WR,   18'h00010, 16'hBEEF, 0, 0, 0, 18'h0,     16'h0,    0, 16'h0000, 2,  1));
    vecs.push_back(mk(OP_RD,   18'h00010, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, UNDRIVEN, 3,  1));
    vecs.push_back(mk(OP_RD,   18'h00010, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, 16'hBEEF, 4,  1));
    vecs.push_back(mk(OP_WR,   18'h00010, 16'h1234, 1, 0, 0, 18'h0,     16'h0,    0, 16'h0000, 4,  2));
    vecs.push_back(mk(OP_RD,   18'h00010, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, UNDRIVEN, 5,  2));
    vecs.push_back(mk(OP_RD,   18'h00010, 16'h0,    0, 1, 0, 18'h0,     16'h0,    1, 16'hBE34, 6,  2));
    vecs.push_back(mk(OP_RD,   18'h00010, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, 16'hBE00, 7,  2));
    vecs.push_back(mk(OP_WR,   18'h00020, 16'h1111, 0, 0, 1, 18'h00020, 16'hCAFE, 0, 16'h0000, 7,  2));
    vecs.push_back(mk(OP_RD,   18'h00020, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, UNDRIVEN, 8,  2));
    vecs.push_back(mk(OP_RD,   18'h00020, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, 16'hCAFE, 9,  2));
    vecs.push_back(mk(OP_IDLE, 18'h00020, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, UNDRIVEN, 9,  2));
    vecs.push_back(mk(OP_IDLE, 18'h0,     16'h0,    0, 0, 1, 18'h00430, 16'h1357, 1, UNDRIVEN, 9,  2));
    vecs.push_back(mk(OP_RD,   18'h00030, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, UNDRIVEN, 10, 2));
    vecs.push_back(mk(OP_RD,   18'h00030, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, 16'h1357, 11, 2));
    vecs.push_back(mk(OP_RD,   18'h00430, 16'h0,    1, 1, 0, 18'h0,     16'h0,    1, 16'h1357, 12, 2));
    vecs.push_back(mk(OP_RD,   18'h00410, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, 16'h0000, 13, 2));
    vecs.push_back(mk(OP_RD,   18'h00000, 16'h0,    0, 0, 0, 18'h0,     16'h0,    1, 16'hBE34, 14, 2));
    vecs.push_back(mk(OP_IDLE, 18'h0,     16'h0,    0, 0, 0, 18'h0,     16'h0,    1, UNDRIVEN, 14, 2));

    // Reset state, with a read request presented so drive_valid matters.
    reset = 1'b0;
    drive_bus(OP_RD, 18'h00005, 16'h0, 1'b0, 1'b0);
    drive_load(1'b0, 18'h0, 16'h0);
    step(); step();
    check("reset init_done", init_done1, 0);
    check("reset rd_count", rd_count1, 0);
    check("reset wr_count", wr_count1, 0);
    check("reset bus", bus1, UNDRIVEN);

    // Fill timing: init_done must rise on exactly the 1024th edge.
    reset = 1'b1;
    run_fill(edges, driven);
    check("fill edges", edges, 1024);
    check("fill init_done lat3", init_done3, 1);
    check("fill bus driven cycles", driven, 0);
    check("fill rd_count", rd_count1, 0);
    check("fill wr_count", wr_count1, 0);

    foreach (vecs[i]) begin
      drive_bus(vecs[i].op, vecs[i].a, vecs[i].wd, vecs[i].hb, vecs[i].lb);
      drive_load(vecs[i].ld, vecs[i].ld_a, vecs[i].ld_d);
      step();
      if (vecs[i].chk_bus) check($sformatf("row%0d bus", i), bus1, vecs[i].exp_bus);
      check($sformatf("row%0d rd_count", i), rd_count1, vecs[i].exp_rd);
      check($sformatf("row%0d wr_count", i), wr_count1, vecs[i].exp_wr);
    end
    drive_load(1'b0, 18'h0, 16'h0);

    // Preload 0xA0..0xA3; the loads also flush both pipelines.
    drive_bus(OP_IDLE, 18'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_load(1'b1, 18'(i), 16'h00A0 + 16'(i));
      step();
    end
    drive_load(1'b0, 18'h0, 16'h0);

    // READ_LAT=3: reads on edges 0..3 appear on edges 3..6.
    for (int e = 0; e < 7; e++) begin
      drive_bus(OP_RD, (e < 4) ? 18'(e) : 18'h00100, 16'h0, 1'b0, 1'b0);
      step();
      if (e < 3) check($sformatf("lat3 edge%0d empty", e), bus3, UNDRIVEN);
      else check($sformatf("lat3 edge%0d data", e), bus3, 16'h00A0 + 16'(e - 3));
    end
    chip_en = 1'b1;
    #1;
    check("lat3 chip_en release", bus3, UNDRIVEN);
    check("lat3 rd_count", rd_count3, 21);

    // Same burst, but the controller turns the bus around after edge 4.
    for (int e = 0; e < 5; e++) begin
      drive_bus(OP_RD, (e < 4) ? 18'(e) : 18'h00100, 16'h0, 1'b0, 1'b0);
      step();
      if (e == 3) check("turn edge3 data", bus3, 16'h00A0);
      if (e == 4) check("turn edge4 data", bus3, 16'h00A1);
    end
    wre       = 1'b0;
    hb_mask   = 1'b1;
    lb_mask   = 1'b1;
    tb_drv_en = 1'b0;
    #1;
    check("turn wre release", bus3, UNDRIVEN);
    step();
    check("turn masked write counted", wr_count3, 3);
    for (int e = 6; e < 8; e++) begin
      drive_bus(OP_RD, 18'h00100, 16'h0, 1'b0, 1'b0);
      step();
      check($sformatf("turn edge%0d flushed", e), bus3, UNDRIVEN);
    end
    check("turn rd_count lat3", rd_count3, 28);
    check("turn rd_count lat1", rd_count1, 28);
    drive_bus(OP_IDLE, 18'h0, 16'h0, 1'b0, 1'b0);
    step();
    check("word 0x3 untouched by masked write", 32'(u_dut1.mem[3]), 32'h00A3);

    // Reset clears counters; a second reset mid-fill restarts the fill.
    reset = 1'b0;
    #1;
    check("rst rd_count", rd_count1, 0);
    check("rst wr_count", wr_count3, 0);
    check("rst init_done", init_done1, 0);
    step();
    reset = 1'b1;
    for (int e = 0; e < 500; e++) step();
    reset = 1'b0;
    #1;
    check("midfill init_done", init_done3, 0);
    step();
    reset = 1'b1;
    run_fill(edges, driven);
    check("refill edges", edges, 1024);
    check("refill bus driven cycles", driven, 0);
    check("refill rd_count", rd_count1, 0);
    check("refill wr_count", wr_count1, 0);

    // Word 0x10 held 0xBE34 before; the refill must have cleared it.
    drive_bus(OP_RD, 18'h00010, 16'h0, 1'b0, 1'b0);
    step();
    step();
    check("refill word 0x10", bus1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
